// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC owner: selects next PC, issues registered flush pulses, one-cycle redirect window.
// Optional branch/jump/flush counters are built when PC_BRANCH_STATS_EN is defined.
module pc_redirect_ctrl #(
    parameter int unsigned         ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter logic [ADDR_W-1:0]   EXC_VECTOR = ADDR_W'(32'h0000_0180)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              addr_err
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       jump_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic {
        RUN,
        REDIRECT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] sel_target;
    logic              misaligned;

    assign pc_plus4 = pc + ADDR_W'(4);

    always_comb begin
        sel_target = branch_taken ? branch_target : jump_target;
        misaligned = (sel_target[1:0] != 2'b00);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_flush <= 1'b0;
            id_ex_flush <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            if_id_flush <= 1'b0;
            id_ex_flush <= 1'b0;
            addr_err    <= 1'b0;
            case (state)
                RUN: begin
                    // A redirect overrides stall; branch beats jump and the jump is simply dropped.
                    if (branch_taken || jump) begin
                        pc          <= misaligned ? EXC_VECTOR : sel_target;
                        if_id_flush <= 1'b1;
                        id_ex_flush <= branch_taken;
                        addr_err    <= misaligned;
                        state       <= REDIRECT;
                    end else if (!stall) begin
                        pc <= pc_plus4;
                    end
                end
                REDIRECT: begin
                    // Requests here come from squashed instructions and are ignored.
                    if (!stall) begin
                        pc <= pc_plus4;
                    end
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt <= '0;
            jump_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN && branch_taken && taken_cnt != '1) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if (state == RUN && !branch_taken && jump && jump_cnt != '1) begin
                jump_cnt <= jump_cnt + 16'd1;
            end
            if (if_id_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized bench for pc_redirect_ctrl with a cycle-indexed reference model and directed anchors.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC    = 32'h0000_0180;

    logic        clock;
    logic        reset_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    pc_redirect_ctrl #(
        .ADDR_W     (32),
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .stall         (stall),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .addr_err      (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges are numbered; a request is honoured unless the
    // previous edge performed a transfer (that edge's successor is the dead window).
    function automatic logic [31:0] dest(input logic b, input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] t;
        t = b ? bt : jt;
        return (t[1:0] != 2'b00) ? EXC : t;
    endfunction

    function automatic logic bad_align(input logic b, input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] t;
        t = b ? bt : jt;
        return t[1:0] != 2'b00;
    endfunction

    logic [31:0] m_pc;
    logic        m_ifid, m_idex, m_err;
    int          m_edge, m_last;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pc   <= RST_PC;
            m_ifid <= 1'b0;
            m_idex <= 1'b0;
            m_err  <= 1'b0;
            m_edge <= 0;
            m_last <= -10;
        end else begin
            m_edge <= m_edge + 1;
            if (m_edge != m_last + 1 && (branch_taken === 1'b1 || jump === 1'b1)) begin
                m_pc   <= dest(branch_taken, branch_target, jump_target);
                m_err  <= bad_align(branch_taken, branch_target, jump_target);
                m_ifid <= 1'b1;
                m_idex <= branch_taken;
                m_last <= m_edge;
            end else begin
                m_ifid <= 1'b0;
                m_idex <= 1'b0;
                m_err  <= 1'b0;
                if (stall !== 1'b1) m_pc <= m_pc + 32'd4;
            end
        end
    end

    logic prev_flush = 1'b0;
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, m_ifid});
            chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, m_idex});
            chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
            if (prev_flush) chk("flush_back_to_back", {31'd0, if_id_flush}, 32'd0);
            prev_flush = if_id_flush;
        end else begin
            prev_flush = 1'b0;
        end
    end

    task automatic step(input logic b, input logic [31:0] bt, input logic j,
                        input logic [31:0] jt, input logic s);
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        stall         = s;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        branch_taken  = 1'bx;
        branch_target = 'x;
        jump          = 1'bx;
        jump_target   = 'x;
        stall         = 1'bx;
        #12;
        chk("reset_pc", pc, 32'h0);
        chk("reset_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("reset_err", {31'd0, addr_err}, 32'd0);
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        branch_target = '0;  jump_target = '0;
        @(negedge clock); #2 reset_n = 1'b1;

        repeat (4) idle();
        chk("freerun_pc", pc, 32'h10);

        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        chk("br_pc", pc, 32'h40);
        chk("br_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        idle();
        chk("br_after_pc", pc, 32'h44);
        chk("br_after_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);

        step(1'b1, 32'h80, 1'b1, 32'h200, 1'b1);
        chk("prio_pc", pc, 32'h80);
        chk("prio_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        idle();

        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("window_pc", pc, 32'h44);
        chk("window_flush", {31'd0, if_id_flush}, 32'd0);

        step(1'b1, 32'h42, 1'b0, 32'h0, 1'b0);
        chk("misalign_pc", pc, 32'h180);
        chk("misalign_err", {29'd0, addr_err, if_id_flush, id_ex_flush}, 32'd7);
        idle();
        chk("misalign_err_once", {31'd0, addr_err}, 32'd0);
        chk("misalign_next_pc", pc, 32'h184);

        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("jump_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd2);
        chk("wrap_plus4", pc_plus4, 32'h0);
        idle();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_err", {31'd0, addr_err}, 32'd0);

        step(1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("redirect_stall_pc", pc, 32'h300);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
            step($urandom_range(0, 3) == 0, bt, $urandom_range(0, 3) == 0, jt,
                 $urandom_range(0, 2) == 0);
        end

        idle();
        step(1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        branch_taken = 1'bx; jump = 1'bx; stall = 1'bx;
        #1;
        chk("midreset_pc", pc, RST_PC);
        chk("midreset_flush", {29'd0, addr_err, if_id_flush, id_ex_flush}, 32'd0);
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        @(negedge clock); #2 reset_n = 1'b1;
        idle();
        chk("postreset_pc", pc, 32'h4);
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch-stage PC owner, directly downstream of the BEQ/BNE branch-decision gate.
- Consumes the gate's branch-taken decision plus the branch target and holds the program counter.
- Selects the next PC and generates registered flush pulses for the IF/ID and ID/EX pipeline registers.
- Enforces a one-cycle redirect window after any control transfer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC loaded on a misaligned branch or jump target.
- ADDR_W, 32, PC and target width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- branch_taken  in  1  output of the BEQ/BNE decision gate; branch resolved this cycle.
- branch_target  in  ADDR_W  branch destination, valid with branch_taken.
- jump  in  1  unconditional jump request.
- jump_target  in  ADDR_W  jump destination, valid with jump.
- stall  in  1  hazard-unit freeze request.
- pc  out  ADDR_W  current fetch address, registered.
- pc_plus4  out  ADDR_W  pc + 4, combinational, mod 2^ADDR_W.
- if_id_flush  out  1  registered one-cycle squash pulse for IF/ID.
- id_ex_flush  out  1  registered one-cycle squash pulse for ID/EX.
- addr_err  out  1  registered one-cycle pulse on a misaligned target.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc=RESET_PC.
  - if_id_flush=0, id_ex_flush=0, addr_err=0.
  - FSM=RUN.
  - Any in-progress redirect is abandoned.
- FSM states: RUN, REDIRECT.
- RUN next-PC priority, highest first:
  - branch_taken=1: pc<=branch_target; if_id_flush<=1; id_ex_flush<=1; go REDIRECT.
  - jump=1: pc<=jump_target; if_id_flush<=1; id_ex_flush<=0; go REDIRECT.
  - stall=1: pc holds; flushes 0; stay RUN.
  - otherwise: pc<=pc+4; flushes 0.
- branch_taken and jump in the same cycle: branch wins. jump is dropped, not queued.
- branch_taken or jump with stall=1: the redirect wins and stall is ignored that cycle.
- Misaligned target (selected target bits [1:0] != 0):
  - pc<=EXC_VECTOR; addr_err<=1 for one cycle.
  - Flush outputs as for a normal redirect; go REDIRECT.
- REDIRECT lasts exactly one cycle, then returns to RUN:
  - branch_taken and jump are ignored, because they come from squashed instructions.
  - Flush outputs return to 0.
  - stall=0: pc<=pc+4. stall=1: pc holds.
- Flush outputs never assert for two consecutive cycles.
- Wrap-around: pc=32'hFFFF_FFFC sequential step gives 32'h0000_0000, no error.
- Latency:
  - A redirect request in cycle N gives the new pc visible after edge N.
  - The flush pulse is high for cycle N+1 only.
- X on inputs while reset_n=0 must not propagate to outputs.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Enabled, the block adds three outputs:
  - taken_cnt [15:0]: counts accepted branch redirects.
  - jump_cnt [15:0]: counts accepted jumps.
  - flush_cnt [15:0]: counts cycles with if_id_flush=1.
- Counter rules:
  - Ignored requests in REDIRECT do not count.
  - Counters saturate at 16'hFFFF.
  - Counters clear on reset_n=0.
- Disabled: the ports and logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset then free-run, no requests, 4 cycles: pc 0x0 -> 0x4 -> 0x8 -> 0xC -> 0x10; all flushes 0.
- At pc=0x10, branch_taken=1, branch_target=0x40: next pc=0x40; if_id_flush=id_ex_flush=1 for one cycle; following cycle pc=0x44.
- branch_taken=1 (target 0x80) and jump=1 (target 0x200) together, with stall=1: pc=0x80, jump dropped, branch flushes asserted.
- Redirect to 0x40, then branch_taken=1 (target 0x100) in the REDIRECT cycle: request ignored, pc=0x44.
- branch_target=0x42: pc=0x180, addr_err pulses once, both flushes pulse.
- pc forced to 0xFFFF_FFFC with no request: pc=0x0. Separately, reset_n driven low mid-REDIRECT: pc=RESET_PC immediately, flushes 0.
